food_map_scanner: RTL and testbench
===================================

# food_map_scanner

Read-side companion to the pellet-clearing logic. On each `scan_start` pulse, typically the per-frame tick, it sweeps every row of the food map through a dedicated read-only BRAM port and popcounts each 80-bit row. It publishes the number of remaining pellets and a level-clear flag (`all_eaten`) that the game-state controller uses for win detection. It never writes the map; the clearing block owns the write port.

## Interface

- `MAP_ROWS`, 60, number of map rows scanned, addresses 0..MAP_ROWS-1.
- `ROW_BITS`, 80, width of one map row (one bit per tile column).
- `ADDR_W`, 6, map row address width.
- `COUNT_W`, 13, width of the pellet count; must satisfy 2^COUNT_W > MAP_ROWS*ROW_BITS.
- `READ_LATENCY`, 1, cycles from `mem_addr`/`mem_en` sampled to `mem_rdata` valid; legal values 1..3.

Ports:
- `clk`  in  1  single clock for all logic and the BRAM read port.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scan_start`  in  1  request a full-map scan; honoured only in IDLE.
- `mem_en`  out  1  BRAM port enable.
- `mem_addr`  out  ADDR_W  BRAM row address.
- `mem_rdata`  in  ROW_BITS  BRAM row data.
- `busy`  out  1  scan in progress, including DONE.
- `food_count`  out  COUNT_W  pellets remaining at the last completed scan.
- `count_valid`  out  1  one-cycle pulse when `food_count` is updated.
- `all_eaten`  out  1  high when the last completed scan counted 0 pellets.

## Operation

- FSM states:
  - IDLE: `mem_en`=0 and `busy`=0. If `scan_start`=1, clear the accumulator, set the row counter to 0, and go to ISSUE.
  - ISSUE: `mem_en`=1 and `mem_addr`=row counter. The counter increments every cycle. After issuing row MAP_ROWS-1, go to DRAIN.
  - DRAIN: `mem_en`=0. Wait until every issued read has returned, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Return tracking:
  - A READ_LATENCY-deep shift register of valid bits tracks issued reads.
  - When the bit at the tail is set, add popcount(`mem_rdata`) to the accumulator. The popcount is 0..ROW_BITS, 7 bits, zero-extended to COUNT_W.
- Output update:
  - On the edge entering DONE, copy the accumulator to `food_count`.
  - On the same edge, set `all_eaten` = (accumulator == 0) and set `count_valid`=1.
  - `count_valid` clears on the next edge.
- Boundary rules:
  - `scan_start` in ISSUE, DRAIN or DONE is ignored, not queued.
  - No wrap: the accumulator cannot overflow under the COUNT_W rule.
  - Writes by the clearing block during a scan may or may not be reflected. The result is at most one scan stale, and the next scan corrects it.
  - `food_count` and `all_eaten` hold their values between scans.
  - `all_eaten` is never asserted before the first completed scan.
- Reset (any time, including mid-scan):
  - Abort the scan, return to IDLE and clear the shift register and accumulator.
  - Output values: `mem_en`=0, `mem_addr`=0, `busy`=0, `food_count`=0, `count_valid`=0, `all_eaten`=0.

## Timing

- Cycle 0 is the cycle in which `scan_start` is high in IDLE. L is READ_LATENCY.
- Cycles 1..MAP_ROWS: `mem_en`=1 and `mem_addr`=cycle-1.
- Row r data is accumulated at the end of cycle r+1+L. The last accumulation is at the end of cycle MAP_ROWS+L.
- Cycle MAP_ROWS+L+1 (61+L with defaults) is DONE:
  - `count_valid`=1.
  - New `food_count` and `all_eaten` values are visible.
- `busy`=1 for cycles 1..MAP_ROWS+L+1.
- The earliest next accepted `scan_start` is in cycle MAP_ROWS+L+2.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- All-zero map, L=1, `scan_start` at cycle 0:
  - `mem_addr` is 0..59 on cycles 1..60.
  - `count_valid` pulses on cycle 62 with `food_count`=0 and `all_eaten`=1.
- All-ones map:
  - `food_count`=4800 and `all_eaten`=0.
  - A second scan with row 59 bit 79 cleared gives 4799.
- Only row 0 bit 0 and row 59 bit 79 set, L=2:
  - `food_count`=2, with `count_valid` on cycle 63.
  - No rows are lost or double-counted at the pipeline head or tail.
- `scan_start` held high through a whole scan:
  - Exactly one `count_valid` pulse per accepted start.
  - Consecutive accepted starts are 63 cycles apart with L=1.
- `rst_n` low at cycle 30 of a scan over an all-ones map:
  - All outputs go to reset values immediately.
  - After release, a fresh scan reports 4800, not a partial sum.
- Before any scan, over an all-zero map: `all_eaten`=0 and `food_count`=0 are held indefinitely.

Source files
------------

// File: rtl/food_map_scanner_if.sv
// Food-map scanner bundle: scan request, read-only BRAM port and pellet-count status.
// The master side is the scanner; the slave side is the BRAM plus game-state controller.
interface food_map_scanner_if #(
  parameter int ADDR_W   = 6,
  parameter int ROW_BITS = 80,
  parameter int COUNT_W  = 13
);
  logic                scan_start;
  logic                mem_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ROW_BITS-1:0] mem_rdata;
  logic                busy;
  logic [COUNT_W-1:0]  food_count;
  logic                count_valid;
  logic                all_eaten;

  modport master (
    input  scan_start, mem_rdata,
    output mem_en, mem_addr, busy, food_count, count_valid, all_eaten
  );

  modport slave (
    output scan_start, mem_rdata,
    input  mem_en, mem_addr, busy, food_count, count_valid, all_eaten
  );
endinterface

// File: rtl/food_map_scanner.sv
// Sweeps every food-map row on scan_start and popcounts them into a remaining-pellet count.
// Result lands MAP_ROWS+READ_LATENCY+1 cycles after the start; starts outside IDLE are dropped.
module food_map_scanner #(
  parameter int MAP_ROWS     = 60,
  parameter int ROW_BITS     = 80,
  parameter int ADDR_W       = 6,
  parameter int COUNT_W      = 13,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  food_map_scanner_if.master bus
);
  localparam int PC_W = $clog2(ROW_BITS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       row_cnt, row_nxt;
  logic [READ_LATENCY-1:0] vld_sr, vld_nxt;
  logic [READ_LATENCY:0]   vld_ext;
  logic [COUNT_W-1:0]      acc, acc_nxt;
  logic [COUNT_W-1:0]      food_count_q;
  logic                    all_eaten_q;
  logic                    count_valid_q;
  logic [PC_W-1:0]         row_pop;
  logic                    pending;
  logic                    enter_done;

  assign bus.mem_en      = (state == ISSUE);
  assign bus.mem_addr    = row_cnt;
  assign bus.busy        = (state != IDLE);
  assign bus.food_count  = food_count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.all_eaten   = all_eaten_q;

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < ROW_BITS; i++) begin
      row_pop = row_pop + PC_W'(bus.mem_rdata[i]);
    end
  end

  // Each issued read walks to the tail bit, which lines up with its data on mem_rdata.
  assign vld_ext = {vld_sr, bus.mem_en};
  assign vld_nxt = vld_ext[READ_LATENCY-1:0];

  // Reads still in flight behind the one returning this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      pending = pending | vld_sr[i];
    end
  end

  assign enter_done = (state == DRAIN) && !pending;

  always_comb begin
    state_nxt = state;
    row_nxt   = row_cnt;
    acc_nxt   = acc;
    if (vld_sr[READ_LATENCY-1]) begin
      acc_nxt = acc + COUNT_W'(row_pop);
    end
    case (state)
      IDLE: begin
        if (bus.scan_start) begin
          state_nxt = ISSUE;
          row_nxt   = '0;
          acc_nxt   = '0;
        end
      end
      ISSUE: begin
        if (row_cnt == ADDR_W'(MAP_ROWS - 1)) begin
          state_nxt = DRAIN;
          row_nxt   = '0;
        end else begin
          row_nxt = row_cnt + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (!pending) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row_cnt       <= '0;
      vld_sr        <= '0;
      acc           <= '0;
      food_count_q  <= '0;
      all_eaten_q   <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      row_cnt       <= row_nxt;
      vld_sr        <= vld_nxt;
      acc           <= acc_nxt;
      count_valid_q <= enter_done;
      // acc_nxt already includes the final row returning on this edge.
      if (enter_done) begin
        food_count_q <= acc_nxt;
        all_eaten_q  <= (acc_nxt == '0);
      end
    end
  end
endmodule

// File: tb/tb_food_map_scanner.sv
// Bench for food_map_scanner: two instances (read latency 1 and 2) share one food-map model.
// Scan results come from a table of hand-computed vectors plus directed start/reset sequences.
module tb_food_map_scanner;
  localparam int ROWS = 60;
  localparam int BITS = 80;

  logic clk;
  logic rst_n;

  food_map_scanner_if #(.ADDR_W(6), .ROW_BITS(BITS), .COUNT_W(13)) bus1 ();
  food_map_scanner_if #(.ADDR_W(6), .ROW_BITS(BITS), .COUNT_W(13)) bus2 ();

  food_map_scanner #(.MAP_ROWS(ROWS), .ROW_BITS(BITS), .ADDR_W(6), .COUNT_W(13),
                     .READ_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  food_map_scanner #(.MAP_ROWS(ROWS), .ROW_BITS(BITS), .ADDR_W(6), .COUNT_W(13),
                     .READ_LATENCY(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [BITS-1:0] map_mem [64];
  logic [BITS-1:0] stage2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unenabled reads return all-ones so a misaligned accumulate shows up in the count.
  always @(posedge clk) begin
    bus1.mem_rdata <= bus1.mem_en ? map_mem[bus1.mem_addr] : {BITS{1'b1}};
    stage2         <= bus2.mem_en ? map_mem[bus2.mem_addr] : {BITS{1'b1}};
    bus2.mem_rdata <= stage2;
  end

  int sel;
  logic        cur_en, cur_valid, cur_eaten, cur_busy;
  logic [5:0]  cur_addr;
  logic [12:0] cur_count;
  always_comb begin
    cur_en    = (sel == 0) ? bus1.mem_en      : bus2.mem_en;
    cur_addr  = (sel == 0) ? bus1.mem_addr    : bus2.mem_addr;
    cur_valid = (sel == 0) ? bus1.count_valid : bus2.count_valid;
    cur_count = (sel == 0) ? bus1.food_count  : bus2.food_count;
    cur_eaten = (sel == 0) ? bus1.all_eaten   : bus2.all_eaten;
    cur_busy  = (sel == 0) ? bus1.busy        : bus2.busy;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0 all-zero, 1 all-ones, 2 ones minus row59 bit79, 3 row0 bit0 + row59 bit79, 4 row r has r low bits
  task automatic set_map(input int pat);
    for (int r = 0; r < 64; r++) begin
      map_mem[r] = '0;
      if (r < ROWS) begin
        case (pat)
          1, 2: map_mem[r] = {BITS{1'b1}};
          4: for (int b = 0; b < r; b++) map_mem[r][b] = 1'b1;
          default: map_mem[r] = '0;
        endcase
      end
    end
    if (pat == 2) map_mem[59][79] = 1'b0;
    if (pat == 3) begin
      map_mem[0][0]   = 1'b1;
      map_mem[59][79] = 1'b1;
    end
  endtask

  task automatic run_scan(input int s, output int vcyc, output int cnt, output int eaten);
    int addr_err;
    sel = s;
    addr_err = 0;
    vcyc = -1;
    cnt = -1;
    eaten = -1;
    @(negedge clk);
    if (s == 0) bus1.scan_start = 1'b1; else bus2.scan_start = 1'b1;
    for (int c = 1; c <= 200 && vcyc < 0; c++) begin
      @(negedge clk);
      bus1.scan_start = 1'b0;
      bus2.scan_start = 1'b0;
      if (c <= ROWS) begin
        if (cur_en !== 1'b1 || cur_addr !== 6'(c - 1) || cur_busy !== 1'b1) addr_err++;
      end else if (cur_en !== 1'b0 || cur_busy !== 1'b1) begin
        addr_err++;
      end
      if (cur_valid === 1'b1) begin
        vcyc  = c;
        cnt   = int'(cur_count);
        eaten = int'(cur_eaten);
      end
    end
    check("addr_seq", addr_err, 0);
    @(negedge clk);
    check("valid_one_cycle", cur_valid, 0);
    check("idle_after_done", cur_busy, 0);
  endtask

  typedef struct {
    int pat;
    int dut;
    int exp_cnt;
    int exp_eaten;
    int exp_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int vc, cn, ea, errs, np;
    int pulse_cyc[4];
    bus1.scan_start = 1'b0;
    bus2.scan_start = 1'b0;
    sel = 0;
    rst_n = 1'b0;
    set_map(0);

    vecs[0] = '{0, 0, 0,    1, 62};
    vecs[1] = '{1, 0, 4800, 0, 62};
    vecs[2] = '{2, 0, 4799, 0, 62};
    vecs[3] = '{3, 1, 2,    0, 63};
    vecs[4] = '{1, 1, 4800, 0, 63};
    vecs[5] = '{0, 1, 0,    1, 63};
    vecs[6] = '{4, 1, 1770, 0, 63};
    vecs[7] = '{4, 0, 1770, 0, 62};

    repeat (3) @(negedge clk);
    check("rst_mem_en",      bus1.mem_en, 0);
    check("rst_mem_addr",    bus1.mem_addr, 0);
    check("rst_busy",        bus1.busy, 0);
    check("rst_food_count",  bus1.food_count, 0);
    check("rst_count_valid", bus1.count_valid, 0);
    check("rst_all_eaten",   bus1.all_eaten, 0);
    check("rst_all_eaten2",  bus2.all_eaten, 0);
    rst_n = 1'b1;

    // No scan yet over an empty map: nothing may claim the level is clear.
    errs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus1.all_eaten !== 1'b0 || bus1.food_count !== 13'd0 || bus1.count_valid !== 1'b0 ||
          bus1.busy !== 1'b0 || bus1.mem_en !== 1'b0 || bus2.all_eaten !== 1'b0 ||
          bus2.count_valid !== 1'b0) errs++;
    end
    check("idle_hold_pre_scan", errs, 0);

    for (int i = 0; i < 8; i++) begin
      set_map(vecs[i].pat);
      run_scan(vecs[i].dut, vc, cn, ea);
      check($sformatf("vec%0d_valid_cycle", i), vc, vecs[i].exp_cyc);
      check($sformatf("vec%0d_food_count", i), cn, vecs[i].exp_cnt);
      check($sformatf("vec%0d_all_eaten", i), ea, vecs[i].exp_eaten);
    end

    // Results hold between scans even when the map changes underneath.
    set_map(1);
    sel = 0;
    errs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus1.food_count !== 13'd1770 || bus1.all_eaten !== 1'b0 || bus1.count_valid !== 1'b0) errs++;
    end
    check("hold_between_scans", errs, 0);

    // scan_start held high: one pulse per accepted start, starts 63 cycles apart.
    np = 0;
    errs = 0;
    @(negedge clk);
    bus1.scan_start = 1'b1;
    for (int c = 1; c <= 190; c++) begin
      @(negedge clk);
      if (bus1.count_valid === 1'b1) begin
        if (np < 4) pulse_cyc[np] = c;
        np++;
        if (bus1.food_count !== 13'd4800) errs++;
      end
    end
    bus1.scan_start = 1'b0;
    check("held_pulse_count", np, 3);
    check("held_first_pulse", pulse_cyc[0], 62);
    check("held_spacing_a", pulse_cyc[1] - pulse_cyc[0], 63);
    check("held_spacing_b", pulse_cyc[2] - pulse_cyc[1], 63);
    check("held_counts", errs, 0);
    repeat (80) @(negedge clk);

    // Reset asserted at cycle 30 of a scan.
    set_map(1);
    @(negedge clk);
    bus1.scan_start = 1'b1;
    @(negedge clk);
    bus1.scan_start = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_rst_busy", bus1.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_en",      bus1.mem_en, 0);
    check("midrst_mem_addr",    bus1.mem_addr, 0);
    check("midrst_busy",        bus1.busy, 0);
    check("midrst_food_count",  bus1.food_count, 0);
    check("midrst_count_valid", bus1.count_valid, 0);
    check("midrst_all_eaten",   bus1.all_eaten, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_scan(0, vc, cn, ea);
    check("post_rst_valid_cycle", vc, 62);
    check("post_rst_food_count", cn, 4800);
    check("post_rst_all_eaten", ea, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
